// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the AXI-Stream round-robin packet arbiter.
// Holds the two-state FSM encoding and the beat counter width.
package axis_arb_pkg;

   localparam int BEAT_CNT_WIDTH = 16;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rr_priority_encoder.sv
// Combinational round-robin search: first set bit of req at or above ptr,
// wrapping past the top index back to zero.
module rr_priority_encoder #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         found,
   output logic [W-1:0] idx
);

   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         if (!found && req[(int'(ptr) + k) % N]) begin
            found = 1'b1;
            idx   = W'((int'(ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// Packet-granular round-robin arbiter: N AXI-Stream requesters onto one
// master stream, with an optional hard cap on beats per granted packet.
module axis_rr_packet_arbiter
   import axis_arb_pkg::*;
#(
   parameter int NSLAVES    = 4,
   parameter int DATA_WIDTH = 64,
   parameter int MAX_BEATS  = 256,
   parameter int SRC_WIDTH  = $clog2(NSLAVES)
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic [NSLAVES-1:0]            s_enable,
   input  logic [NSLAVES-1:0]            s_valid,
   output logic [NSLAVES-1:0]            s_ready,
   input  logic [NSLAVES*DATA_WIDTH-1:0] s_data,
   input  logic [NSLAVES-1:0]            s_last,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [DATA_WIDTH-1:0]         m_data,
   output logic                          m_last,
   output logic [SRC_WIDTH-1:0]          m_src,
   output logic [NSLAVES-1:0]            grant,
   output logic                          pkt_done,
   output logic                          err_trunc
);

   localparam logic [BEAT_CNT_WIDTH-1:0] LP_CNT_LAST =
      BEAT_CNT_WIDTH'(MAX_BEATS - 1);
   localparam logic [SRC_WIDTH-1:0] LP_SRC_TOP =
      SRC_WIDTH'(NSLAVES - 1);

   arb_state_t                r_state;
   arb_state_t                w_state_nxt;
   logic [SRC_WIDTH-1:0]      r_sel;
   logic [SRC_WIDTH-1:0]      r_ptr;
   logic [BEAT_CNT_WIDTH-1:0] r_beat_cnt;

   logic                      w_found;
   logic [SRC_WIDTH-1:0]      w_idx;
   logic                      w_xfer;
   logic                      w_arb;
   logic                      w_sel_valid;
   logic                      w_sel_last;
   logic                      w_at_max;
   logic                      w_beat;
   logic                      w_end;

   rr_priority_encoder #(
      .N (NSLAVES),
      .W (SRC_WIDTH)
   ) u_rr_enc (
      .req   (s_valid & s_enable),
      .ptr   (r_ptr),
      .found (w_found),
      .idx   (w_idx)
   );

   assign w_xfer      = (r_state == XFER);
   assign w_arb       = (r_state == IDLE) && w_found;
   assign w_sel_valid = s_valid[r_sel];
   assign w_sel_last  = s_last[r_sel];
   assign w_at_max    = (r_beat_cnt == LP_CNT_LAST);
   assign w_beat      = w_xfer && w_sel_valid && m_ready;
   assign w_end       = w_beat && (w_sel_last || w_at_max);

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_found) w_state_nxt = XFER;
         XFER:    if (w_end)   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state    <= IDLE;
         r_sel      <= '0;
         r_ptr      <= '0;
         r_beat_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_arb) begin
            r_sel      <= w_idx;
            r_ptr      <= (w_idx == LP_SRC_TOP) ? '0
                        : w_idx + SRC_WIDTH'(1);
            r_beat_cnt <= '0;
         end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + BEAT_CNT_WIDTH'(1);
         end
      end
   end

   // Everything downstream is gated by XFER so reset silences it at once.
   always_comb begin
      grant   = '0;
      s_ready = '0;
      m_valid = 1'b0;
      m_data  = '0;
      m_last  = 1'b0;
      m_src   = '0;
      if (w_xfer) begin
         grant[r_sel]   = 1'b1;
         s_ready[r_sel] = m_ready;
         m_valid        = w_sel_valid;
         m_data         = s_data[r_sel*DATA_WIDTH +: DATA_WIDTH];
         m_last         = w_sel_last || w_at_max;
         m_src          = r_sel;
      end
   end

   assign pkt_done  = w_end;
   assign err_trunc = w_beat && w_at_max && !w_sel_last;

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Randomized and directed bench for axis_rr_packet_arbiter against a
// packet-level reference model with per-requester beat queues.
module tb_axis_rr_packet_arbiter;

   localparam int NS = 4;
   localparam int DW = 16;
   localparam int MB = 4;
   localparam int SW = 2;

   logic             aclk = 1'b0;
   logic             areset;
   logic [NS-1:0]    s_enable;
   logic [NS-1:0]    s_valid;
   logic [NS-1:0]    s_ready;
   logic [NS*DW-1:0] s_data;
   logic [NS-1:0]    s_last;
   logic             m_valid;
   logic             m_ready;
   logic [DW-1:0]    m_data;
   logic             m_last;
   logic [SW-1:0]    m_src;
   logic [NS-1:0]    grant;
   logic             pkt_done;
   logic             err_trunc;

   int checks   = 0;
   int failures = 0;

   logic [DW:0] q [NS][$];
   int mo, mp, mc;
   int pop_src;
   int ready_mode;
   bit rnd_valid;
   bit rnd_en;
   int seq = 0;
   int n_done, n_err, n_gnt, n_beats;
   int order[$];
   logic [NS-1:0] prev_grant;

   axis_rr_packet_arbiter #(
      .NSLAVES    (NS),
      .DATA_WIDTH (DW),
      .MAX_BEATS  (MB),
      .SRC_WIDTH  (SW)
   ) dut (
      .aclk      (aclk),
      .areset    (areset),
      .s_enable  (s_enable),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last),
      .m_src     (m_src),
      .grant     (grant),
      .pkt_done  (pkt_done),
      .err_trunc (err_trunc)
   );

   always #5 aclk = ~aclk;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic load(int src, int len);
      for (int b = 0; b < len; b++) begin
         q[src].push_back({(b == len - 1),
                           DW'((src << 12) | (seq & 12'hfff))});
         seq++;
      end
   endtask

   task automatic clear_counts();
      n_done  = 0;
      n_err   = 0;
      n_gnt   = 0;
      n_beats = 0;
      order.delete();
      prev_grant = '0;
   endtask

   task automatic check_quiet(string tag);
      check({tag, "_mvalid"}, 64'(m_valid), 0);
      check({tag, "_sready"}, 64'(s_ready), 0);
      check({tag, "_grant"},  64'(grant),   0);
      check({tag, "_done"},   64'(pkt_done), 0);
      check({tag, "_err"},    64'(err_trunc), 0);
      check({tag, "_mlast"},  64'(m_last),  0);
      check({tag, "_msrc"},   64'(m_src),   0);
   endtask

   task automatic drive();
      for (int i = 0; i < NS; i++) begin
         logic hv;
         hv = (q[i].size() > 0) &&
              (!rnd_valid || ($urandom_range(0, 3) != 0));
         s_valid[i] = hv;
         if (hv) begin
            s_data[i*DW +: DW] = q[i][0][DW-1:0];
            s_last[i]          = q[i][0][DW];
         end else begin
            s_data[i*DW +: DW] = DW'($urandom);
            s_last[i]          = 1'($urandom);
         end
      end
      case (ready_mode)
         0:       m_ready = 1'b1;
         1:       m_ready = 1'($urandom_range(0, 1));
         default: m_ready = ~m_ready;
      endcase
      if (rnd_en && ($urandom_range(0, 15) == 0))
         s_enable = NS'($urandom);
   endtask

   task automatic observe();
      logic [NS-1:0] eg;
      logic          xv, xl, hit, bt, fnd;
      int            o;
      pop_src = -1;
      if (pkt_done)  n_done++;
      if (err_trunc) n_err++;
      if (grant != 0) n_gnt++;
      if (grant != 0 && prev_grant == 0) order.push_back(int'(m_src));
      prev_grant = grant;
      if (m_valid && m_ready) n_beats++;
      if (mo < 0) begin
         check("idle_grant",  64'(grant),     0);
         check("idle_mvalid", 64'(m_valid),   0);
         check("idle_sready", 64'(s_ready),   0);
         check("idle_done",   64'(pkt_done),  0);
         check("idle_err",    64'(err_trunc), 0);
         eg  = s_valid & s_enable;
         fnd = 1'b0;
         for (int k = 0; k < NS; k++) begin
            if (!fnd && eg[(mp + k) % NS]) begin
               fnd = 1'b1;
               mo  = (mp + k) % NS;
            end
         end
         if (fnd) begin
            mp = (mo + 1) % NS;
            mc = 0;
         end
      end else begin
         o   = mo;
         xv  = s_valid[o];
         xl  = s_last[o];
         bt  = xv && m_ready;
         hit = (mc + 1 == MB);
         check("xf_grant",  64'(grant),   64'(1 << o));
         check("xf_mvalid", 64'(m_valid), 64'(xv));
         check("xf_sready", 64'(s_ready), m_ready ? 64'(1 << o) : 64'd0);
         check("xf_msrc",   64'(m_src),   64'(o));
         if (xv) begin
            check("xf_mdata", 64'(m_data), 64'(q[o][0][DW-1:0]));
            check("xf_mlast", 64'(m_last), 64'(xl || hit));
         end
         check("xf_done", 64'(pkt_done),  64'(bt && (xl || hit)));
         check("xf_err",  64'(err_trunc), 64'(bt && hit && !xl));
         if (bt) begin
            pop_src = o;
            mc++;
            if (xl || hit) mo = -1;
         end
      end
   endtask

   task automatic step();
      drive();
      @(negedge aclk);
      observe();
      @(posedge aclk);
      if (pop_src >= 0) void'(q[pop_src].pop_front());
      #1;
   endtask

   task automatic do_reset();
      areset  = 1'b1;
      s_valid = '0;
      #1;
      check_quiet("rst");
      for (int i = 0; i < NS; i++) q[i].delete();
      mo = -1;
      mp = 0;
      mc = 0;
      clear_counts();
      @(posedge aclk);
      @(posedge aclk);
      #1;
      areset = 1'b0;
   endtask

   initial begin
      int guard;
      areset     = 1'b1;
      s_enable   = '1;
      s_valid    = '0;
      s_last     = '0;
      s_data     = '0;
      m_ready    = 1'b0;
      ready_mode = 0;
      rnd_valid  = 1'b0;
      rnd_en     = 1'b0;

      // four 3-beat packets, everyone enabled
      do_reset();
      for (int i = 0; i < NS; i++) load(i, 3);
      repeat (20) step();
      for (int k = 0; k < NS; k++)
         check("t1_order", 64'(order.size() > k ? order[k] : -1), 64'(k));
      check("t1_done", 64'(n_done), 4);

      // pointer moves past the last winner
      do_reset();
      load(2, 1);
      repeat (2) step();
      load(0, 2);
      load(3, 2);
      repeat (12) step();
      check("t2_o0", 64'(order.size() > 0 ? order[0] : -1), 2);
      check("t2_o1", 64'(order.size() > 1 ? order[1] : -1), 3);
      check("t2_o2", 64'(order.size() > 2 ? order[2] : -1), 0);

      // 6-beat packet truncated at 4
      do_reset();
      load(1, 6);
      repeat (15) step();
      check("t3_err",  64'(n_err),  1);
      check("t3_done", 64'(n_done), 2);
      check("t3_npkt", 64'(order.size()), 2);
      check("t3_left", 64'(q[1].size()), 0);

      // exactly MAX_BEATS with last on the final beat
      do_reset();
      load(1, 4);
      repeat (10) step();
      check("t4_err",  64'(n_err),  0);
      check("t4_done", 64'(n_done), 1);

      // valid but disabled requester is never served
      do_reset();
      s_enable = 4'b1011;
      load(2, 3);
      repeat (20) step();
      check("t5_gnt", 64'(n_gnt), 0);
      check("t5_left", 64'(q[2].size()), 3);

      // reset in the middle of a packet
      do_reset();
      s_enable   = '1;
      ready_mode = 2;
      load(2, 5);
      guard = 0;
      while (n_beats < 1 && guard < 40) begin
         step();
         guard++;
      end
      check("t6_reach", 64'(n_beats >= 1), 1);
      check("t6_pre_grant", 64'(grant), 64'(4'b0100));
      areset = 1'b1;
      #1;
      check_quiet("t6_async");
      for (int i = 0; i < NS; i++) q[i].delete();
      mo = -1;
      mp = 0;
      mc = 0;
      clear_counts();
      load(1, 2);
      load(3, 2);
      @(posedge aclk);
      #1;
      check_quiet("t6_hold");
      areset     = 1'b0;
      ready_mode = 0;
      repeat (10) step();
      check("t6_first", 64'(order.size() > 0 ? order[0] : -1), 1);

      // randomized traffic with gaps, backpressure and enable churn
      do_reset();
      s_enable   = '1;
      rnd_valid  = 1'b1;
      rnd_en     = 1'b1;
      ready_mode = 1;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            int s;
            s = $urandom_range(0, NS - 1);
            if (q[s].size() < 8) load(s, $urandom_range(1, 7));
         end
         step();
      end
      check("t7_progress", 64'(n_done > 20), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
